// File: rtl/sim_mem_trace_lane_queue.sv
// Per-lane decoupling queue between the trace reader and the per-lane memory
// request ports. Each accepted bundle is split into independent lane FIFOs,
// each lane replays its head entry (optionally held back until the replay
// cycle reaches the entry's stamp), and a sticky "finished" flag reports that
// the trace is exhausted and every lane has drained.
module sim_mem_trace_lane_queue #(
    parameter int NUM_LANES     = 4,
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int LOGSIZE_WIDTH = 8,
    parameter int GATE_BY_CYCLE = 1
) (
    input  logic                                       clock,
    input  logic                                       reset,
    output logic [63:0]                                trace_read_cycle,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [63:0]                                in_cycle,
    input  logic [NUM_LANES-1:0]                       in_lane_valid,
    input  logic [ADDR_WIDTH*NUM_LANES-1:0]            in_address,
    input  logic [NUM_LANES-1:0]                       in_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0]         in_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]            in_data,
    input  logic                                       in_finished,
    output logic [NUM_LANES-1:0]                       out_valid,
    input  logic [NUM_LANES-1:0]                       out_ready,
    output logic [ADDR_WIDTH*NUM_LANES-1:0]            out_address,
    output logic [NUM_LANES-1:0]                       out_is_store,
    output logic [LOGSIZE_WIDTH*NUM_LANES-1:0]         out_size,
    output logic [DATA_WIDTH*NUM_LANES-1:0]            out_data,
    output logic [NUM_LANES*($clog2(DEPTH)+1)-1:0]     lane_count,
    output logic [31:0]                                req_count,
    output logic                                       finished
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]          cycle_reg;
    logic [31:0]          req_count_reg;
    logic [31:0]          issued;
    logic                 latch_reg;
    logic                 finished_reg;
    logic [NUM_LANES-1:0] full;
    logic [NUM_LANES-1:0] empty;
    logic [NUM_LANES-1:0] fire;
    logic                 accept;

    // A full lane blocks the whole bundle, whether or not that lane is used,
    // so in_ready only ever looks at registered occupancy.
    assign in_ready = reset & ~(|full);
    assign accept   = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [ADDR_WIDTH-1:0]    addr_mem  [DEPTH];
            logic                     store_mem [DEPTH];
            logic [LOGSIZE_WIDTH-1:0] size_mem  [DEPTH];
            logic [DATA_WIDTH-1:0]    data_mem  [DEPTH];
            logic [63:0]              stamp_mem [DEPTH];
            logic [PW-1:0]            wr_ptr_reg;
            logic [PW-1:0]            rd_ptr_reg;
            logic [CW-1:0]            count_reg;
            logic                     enq;
            logic                     gate_ok;

            assign full[gi]  = (count_reg == CW'(DEPTH));
            assign empty[gi] = (count_reg == '0);
            assign enq       = accept & in_lane_valid[gi];
            assign gate_ok   = (GATE_BY_CYCLE == 0) || (cycle_reg >= stamp_mem[rd_ptr_reg]);
            assign out_valid[gi] = reset & ~empty[gi] & gate_ok;
            assign fire[gi]      = out_valid[gi] & out_ready[gi];

            assign out_address[gi*ADDR_WIDTH +: ADDR_WIDTH]       = addr_mem[rd_ptr_reg];
            assign out_is_store[gi]                               = store_mem[rd_ptr_reg];
            assign out_size[gi*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]    = size_mem[rd_ptr_reg];
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]          = data_mem[rd_ptr_reg];
            assign lane_count[gi*CW +: CW]                        = count_reg;

            // Entry storage: written at the tail, no reset needed since the
            // occupancy counter decides what is valid.
            always_ff @(posedge clock) begin
                if (enq) begin
                    addr_mem[wr_ptr_reg]  <= in_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
                    store_mem[wr_ptr_reg] <= in_is_store[gi];
                    size_mem[wr_ptr_reg]  <= in_size[gi*LOGSIZE_WIDTH +: LOGSIZE_WIDTH];
                    data_mem[wr_ptr_reg]  <= in_data[gi*DATA_WIDTH +: DATA_WIDTH];
                    stamp_mem[wr_ptr_reg] <= in_cycle;
                end
            end

            // Pointers wrap naturally; the counter separates full from empty.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (enq)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fire[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    case ({enq, fire[gi]})
                        2'b10:   count_reg <= count_reg + 1'b1;
                        2'b01:   count_reg <= count_reg - 1'b1;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Number of lane requests consumed this cycle.
    always_comb begin
        issued = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            issued = issued + 32'(fire[i]);
        end
    end

    // Replay cycle counter and issued-request counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cycle_reg     <= '0;
            req_count_reg <= '0;
        end else begin
            cycle_reg     <= cycle_reg + 64'd1;
            req_count_reg <= req_count_reg + issued;
        end
    end

    // Sticky end-of-trace latch and drained indication; a bundle accepted in
    // the same cycle keeps finished low because it refills a lane.
    always_ff @(posedge clock) begin
        if (!reset) begin
            latch_reg    <= 1'b0;
            finished_reg <= 1'b0;
        end else begin
            if (in_finished) latch_reg <= 1'b1;
            if ((latch_reg | in_finished) & (&empty) & ~accept) finished_reg <= 1'b1;
        end
    end

    assign trace_read_cycle = cycle_reg;
    assign req_count        = req_count_reg;
    assign finished         = finished_reg;

endmodule

// File: tb/tb_sim_mem_trace_lane_queue.sv
// Randomized plus directed bench for sim_mem_trace_lane_queue, checked against
// a queue-based reference model of the lane behaviour.
module tb_sim_mem_trace_lane_queue;

    localparam int NL = 4;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [63:0]       trace_read_cycle;
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_cycle;
    logic [NL-1:0]     in_lane_valid;
    logic [64*NL-1:0]  in_address;
    logic [NL-1:0]     in_is_store;
    logic [8*NL-1:0]   in_size;
    logic [64*NL-1:0]  in_data;
    logic              in_finished;
    logic [NL-1:0]     out_valid;
    logic [NL-1:0]     out_ready;
    logic [64*NL-1:0]  out_address;
    logic [NL-1:0]     out_is_store;
    logic [8*NL-1:0]   out_size;
    logic [64*NL-1:0]  out_data;
    logic [NL*CW-1:0]  lane_count;
    logic [31:0]       req_count;
    logic              finished;

    sim_mem_trace_lane_queue #(
        .NUM_LANES(NL), .DEPTH(DEPTH), .ADDR_WIDTH(64), .DATA_WIDTH(64),
        .LOGSIZE_WIDTH(8), .GATE_BY_CYCLE(1)
    ) dut (
        .clock(clock), .reset(reset), .trace_read_cycle(trace_read_cycle),
        .in_valid(in_valid), .in_ready(in_ready), .in_cycle(in_cycle),
        .in_lane_valid(in_lane_valid), .in_address(in_address),
        .in_is_store(in_is_store), .in_size(in_size), .in_data(in_data),
        .in_finished(in_finished), .out_valid(out_valid), .out_ready(out_ready),
        .out_address(out_address), .out_is_store(out_is_store),
        .out_size(out_size), .out_data(out_data), .lane_count(lane_count),
        .req_count(req_count), .finished(finished)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        logic        st;
        logic [7:0]  size;
        logic [63:0] data;
        logic [63:0] stamp;
    } ent_t;

    ent_t        mq [NL][$];
    logic [63:0] m_cycle;
    logic [31:0] m_req;
    logic        m_latch;
    logic        m_fin;
    bit          m_init = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, m_cycle);
        end
    endtask

    function automatic bit exp_ready();
        bit r = (reset === 1'b1);
        for (int l = 0; l < NL; l++) if (mq[l].size() >= DEPTH) r = 0;
        return r;
    endfunction

    function automatic bit exp_valid(input int l);
        if (reset !== 1'b1 || mq[l].size() == 0) return 0;
        return m_cycle >= mq[l][0].stamp;
    endfunction

    // Compare every visible output against the model.
    task automatic check_all();
        if (!m_init) return;
        chk("in_ready", 64'(in_ready), 64'(exp_ready()));
        chk("trace_read_cycle", trace_read_cycle, m_cycle);
        chk("req_count", 64'(req_count), 64'(m_req));
        chk("finished", 64'(finished), 64'(m_fin));
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("lane_count%0d", l), 64'(lane_count[l*CW +: CW]), 64'(mq[l].size()));
            chk($sformatf("out_valid%0d", l), 64'(out_valid[l]), 64'(exp_valid(l)));
            if (exp_valid(l)) begin
                chk($sformatf("addr%0d", l), out_address[l*64 +: 64], mq[l][0].addr);
                chk($sformatf("store%0d", l), 64'(out_is_store[l]), 64'(mq[l][0].st));
                chk($sformatf("size%0d", l), 64'(out_size[l*8 +: 8]), 64'(mq[l][0].size));
                chk($sformatf("data%0d", l), out_data[l*64 +: 64], mq[l][0].data);
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_update();
        bit   acc;
        bit   all_empty;
        bit   v [NL];
        ent_t e;
        if (reset !== 1'b1) begin
            for (int l = 0; l < NL; l++) mq[l].delete();
            m_cycle = 0; m_req = 0; m_latch = 0; m_fin = 0; m_init = 1;
            return;
        end
        acc = in_valid && exp_ready();
        all_empty = 1;
        for (int l = 0; l < NL; l++) begin
            v[l] = exp_valid(l);
            if (mq[l].size() != 0) all_empty = 0;
        end
        for (int l = 0; l < NL; l++) begin
            if (v[l] && out_ready[l]) begin
                void'(mq[l].pop_front());
                m_req++;
            end
            if (acc && in_lane_valid[l]) begin
                e.addr = in_address[l*64 +: 64];
                e.st = in_is_store[l];
                e.size = in_size[l*8 +: 8];
                e.data = in_data[l*64 +: 64];
                e.stamp = in_cycle;
                mq[l].push_back(e);
            end
        end
        if ((m_latch || in_finished) && all_empty && !acc) m_fin = 1;
        if (in_finished) m_latch = 1;
        m_cycle++;
    endtask

    // Inputs are applied at the falling edge; outputs checked 1 time unit later.
    task automatic step();
        #1;
        check_all();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic set_bundle(input logic [NL-1:0] lv, input logic [63:0] stamp);
        in_lane_valid = lv;
        in_cycle = stamp;
        for (int l = 0; l < NL; l++) begin
            in_address[l*64 +: 64] = {$urandom, $urandom};
            in_data[l*64 +: 64] = {$urandom, $urandom};
            in_size[l*8 +: 8] = 8'($urandom_range(0, 6));
            in_is_store[l] = 1'($urandom);
        end
    endtask

    int sent;
    int tries;

    initial begin
        reset = 1'b0; in_valid = 1'b1; out_ready = '1; in_finished = 1'b0;
        set_bundle('1, 64'd0);

        // Reset hold with in_valid and out_ready active.
        repeat (3) step();
        reset = 1'b1; in_valid = 1'b0;
        step();
        $display("reset hold done, trace_read_cycle=%0d", trace_read_cycle);

        // Single two-lane bundle, stamp 0 issues at once.
        set_bundle(4'b0101, 64'd0);
        in_address[0 +: 64] = 64'h1000;
        in_address[128 +: 64] = 64'h2000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        $display("single bundle done, req_count=%0d", req_count);

        // Backpressure on lane 1 until full, then release one slot.
        out_ready = 4'b1101;
        in_valid = 1'b1;
        repeat (5) begin set_bundle(4'b0010, 64'd0); step(); end
        in_valid = 1'b0;
        step();
        out_ready = 4'b1111; step();
        out_ready = 4'b1101; repeat (2) step();
        out_ready = 4'b1111; repeat (5) step();
        $display("backpressure done, lane1 count=%0d", lane_count[CW +: CW]);

        // Cycle gating: stamp 15 cycles ahead holds lane 0 back.
        set_bundle(4'b0001, m_cycle + 64'd15);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        $display("gating done at cycle %0d", m_cycle);

        // Wrap-around: ten ordered entries on lane 3 with alternating ready.
        sent = 0; tries = 0;
        while (sent < 10 && tries < 100) begin
            set_bundle(4'b1000, 64'd0);
            in_address[192 +: 64] = 64'(sent);
            in_valid = 1'b1;
            out_ready[3] = 1'(tries % 2);
            if (exp_ready()) sent++;
            tries++;
            step();
        end
        chk("wrap_sent", 64'(sent), 64'd10);
        in_valid = 1'b0; out_ready = '1;
        repeat (6) step();
        $display("wrap done, req_count=%0d", req_count);

        // Finished with two entries queued, then reset mid-queue.
        out_ready = '0;
        in_valid = 1'b1;
        repeat (2) begin set_bundle(4'b0001, 64'd0); step(); end
        in_valid = 1'b0; in_finished = 1'b1;
        step();
        in_finished = 1'b0;
        repeat (3) step();
        out_ready = '1;
        repeat (5) step();
        out_ready = '0;
        in_valid = 1'b1; set_bundle(4'b0110, 64'd0);
        step();
        in_valid = 1'b0; reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        $display("finished/reset done, finished=%0b", finished);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            set_bundle(4'($urandom), m_cycle + 64'($urandom_range(0, 8)) - 64'd3);
            in_valid = ($urandom_range(0, 99) < 60);
            out_ready = 4'($urandom);
            in_finished = ($urandom_range(0, 99) < 1);
            reset = !($urandom_range(0, 199) < 1);
            step();
        end
        reset = 1'b1; in_valid = 1'b0; in_finished = 1'b0; out_ready = '1;
        repeat (12) step();
        $display("random phase done, req_count=%0d finished=%0b", req_count, finished);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
